// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    // funct3 encodings for the M extension
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Most-negative dividend; DIV of it by -1 overflows and returns itself
    localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the register file and the mul/div unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [4:0]       rd_addr;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             we_out;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_addr,
        input  busy, done, result, rd_out, we_out
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_addr,
        output busy, done, result, rd_out, we_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide,
// one bit per cycle, sharing one counter and one 2*WIDTH shift register.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; captures operands, resolves special cases
// S_CALC | WIDTH iterations of shift-add or restoring divide
// S_FIX  | apply latched sign, select word, load result/rd_out
// S_DONE | done/we pulse, result valid
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
)
(
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] INT_MIN = {DIV_OVF_DIVIDEND[XLEN-1], {(WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [4:0]         rd_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         rd_out_q;

    // operand decode on the live inputs (only meaningful in IDLE)
    logic [2:0]       f3;
    logic [WIDTH-1:0] a_in, b_in, a_abs, b_abs, special_val;
    logic             sgn_a, sgn_b, a_neg, b_neg, is_div_in, neg_in;
    logic             div_zero, div_ovf, special;

    assign f3        = bus.funct3;
    assign a_in      = bus.rs1_val;
    assign b_in      = bus.rs2_val;
    assign is_div_in = f3[2];
    assign sgn_a     = (f3 == OP_MUL) || (f3 == OP_MULH) || (f3 == OP_MULHSU) ||
                       (f3 == OP_DIV) || (f3 == OP_REM);
    assign sgn_b     = (f3 == OP_MUL) || (f3 == OP_MULH) ||
                       (f3 == OP_DIV) || (f3 == OP_REM);
    assign a_neg     = sgn_a & a_in[WIDTH-1];
    assign b_neg     = sgn_b & b_in[WIDTH-1];
    assign a_abs     = a_neg ? (~a_in + 1'b1) : a_in;
    assign b_abs     = b_neg ? (~b_in + 1'b1) : b_in;
    assign neg_in    = !is_div_in        ? (a_neg ^ b_neg) :
                       (f3 == OP_DIV)    ? (a_neg ^ b_neg) :
                       (f3 == OP_REM)    ? a_neg : 1'b0;
    assign div_zero  = is_div_in && (b_in == '0);
    assign div_ovf   = ((f3 == OP_DIV) || (f3 == OP_REM)) &&
                       (a_in == INT_MIN) && (b_in == '1);
    assign special   = div_zero | div_ovf;
    // funct3[1] low selects the quotient forms (DIV/DIVU)
    assign special_val = div_zero ? (f3[1] ? a_in : '1)
                                  : (f3[1] ? '0 : INT_MIN);

    // one iteration step for each algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_new;

    assign mul_sum  = acc[0] ? ({1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                             : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, mcand};
    assign rem_ge   = (rem_sh >= {1'b0, mcand});
    assign rem_new  = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    // sign fix-up and word selection used in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_sel, final_val;

    assign prod_fix  = neg_q ? (~acc + 1'b1) : acc;
    assign div_sel   = op_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
    assign final_val = !op_q[2]          ? ((op_q == OP_MUL) ? prod_fix[WIDTH-1:0]
                                                             : prod_fix[2*WIDTH-1:WIDTH]) :
                       neg_q             ? (~div_sel + 1'b1) : div_sel;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.start) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // handshake outputs
    logic busy_c, done_c;
    always_comb begin
        busy_c = (state != S_IDLE);
        done_c = (state == S_DONE);
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.we_out = done_c && (rd_out_q != 5'd0);

    // operand capture, iteration datapath and result/rd_out load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q  <= f3;
                        rd_q  <= bus.rd_addr;
                        neg_q <= neg_in;
                        cnt   <= CW'(WIDTH - 1);
                        if (is_div_in) begin
                            mcand <= b_abs;
                            acc   <= {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            mcand <= a_abs;
                            acc   <= {{WIDTH{1'b0}}, b_abs};
                        end
                        if (special) begin
                            result_q <= special_val;
                            rd_out_q <= bus.rd_addr;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (op_q[2]) acc <= {rem_new, acc[WIDTH-2:0], rem_ge};
                    else         acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                S_FIX: begin
                    result_q <= final_val;
                    rd_out_q <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule
